// File: rtl/share_write_master_if.sv
// Output-buffer line stream and Avalon-MM write bus
// of the conv datapath write master.
interface share_write_master_if;
    logic         OBValid_i;
    logic [511:0] OBLine_i;
    logic         OBFirst_i;
    logic         OBLast_i;
    logic         OBReady_o;
    logic [63:0]  AvalonAddr_o;
    logic         AvalonRead_o;
    logic         AvalonWrite_o;
    logic [63:0]  AvalonByteEnable_o;
    logic [511:0] AvalonWriteData_o;
    logic [511:0] AvalonReadData_i;
    logic         AvalonLock_o;
    logic         AvalonWaitReq_i;

    modport master (
        input  OBValid_i, OBLine_i, OBFirst_i, OBLast_i,
        output OBReady_o,
        output AvalonAddr_o, AvalonRead_o, AvalonWrite_o,
        output AvalonByteEnable_o, AvalonWriteData_o,
        input  AvalonReadData_i,
        output AvalonLock_o,
        input  AvalonWaitReq_i
    );

    modport slave (
        output OBValid_i, OBLine_i, OBFirst_i, OBLast_i,
        input  OBReady_o,
        input  AvalonAddr_o, AvalonRead_o, AvalonWrite_o,
        input  AvalonByteEnable_o, AvalonWriteData_o,
        output AvalonReadData_i,
        input  AvalonLock_o,
        output AvalonWaitReq_i
    );
endinterface

// File: rtl/share_write_master.sv
// Avalon-MM write-only master: stages output lines in a FIFO
// and writes them to consecutive word addresses.
module share_write_master #(
    parameter logic [63:0] InitialOutAddr = 64'h0,
    parameter int unsigned FifoDepth      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Start_i,
    input  logic [8:0]                  Height_i,
    input  logic                        Halt_i,
    share_write_master_if.master        bus,
    output logic                        Busy_o,
    output logic                        Done_o,
    output logic                        Error_o
);
    localparam int AW = $clog2(FifoDepth);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [8:0]      height_q, height_d;
    logic [8:0]      in_cnt_q, in_cnt_d;
    logic [8:0]      out_cnt_q, out_cnt_d;
    logic            err_q, err_d;
    logic            pend_q, pend_d;
    logic            done_q, done_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic [511:0]    mem_q [FifoDepth];

    logic run, full, empty, ready, wr, push, pop;
    logic first_bad, last_bad;

    // Full flag comes from the registered count, so a pop frees a slot next cycle.
    assign full  = (cnt_q == (AW+1)'(FifoDepth));
    assign empty = (cnt_q == '0);
    assign run   = (state_q == RUN);
    assign ready = run & ~full & (in_cnt_q != height_q);
    assign wr    = run & (pend_q | (~empty & ~Halt_i));
    assign push  = bus.OBValid_i & ready;
    assign pop   = wr & ~bus.AvalonWaitReq_i;

    assign first_bad = bus.OBFirst_i != (in_cnt_q == 9'd0);
    assign last_bad  = bus.OBLast_i  != (in_cnt_q == height_q - 9'd1);

    always_comb begin
        state_d   = state_q;
        height_d  = height_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        pend_d    = 1'b0;
        done_d    = (state_q == DONE);
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        unique case (state_q)
            IDLE: begin
                if (Start_i) begin
                    height_d  = Height_i;
                    in_cnt_d  = 9'd0;
                    out_cnt_d = 9'd0;
                    err_d     = 1'b0;
                    state_d   = (Height_i == 9'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                pend_d = wr & bus.AvalonWaitReq_i;
                if (push) begin
                    in_cnt_d = in_cnt_q + 9'd1;
                    if (first_bad | last_bad) err_d = 1'b1;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 9'd1;
                    if (out_cnt_q == height_q - 9'd1) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            height_q  <= 9'd0;
            in_cnt_q  <= 9'd0;
            out_cnt_q <= 9'd0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            height_q  <= height_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.OBLine_i;
    end

    assign bus.OBReady_o          = ready;
    assign bus.AvalonWrite_o      = wr;
    assign bus.AvalonRead_o       = 1'b0;
    assign bus.AvalonAddr_o       = wr ? InitialOutAddr + {55'd0, out_cnt_q} : 64'd0;
    assign bus.AvalonByteEnable_o = {64{wr}};
    assign bus.AvalonWriteData_o  = wr ? mem_q[rptr_q] : 512'd0;
    assign bus.AvalonLock_o       = run;
    assign Busy_o                 = (state_q != IDLE);
    assign Done_o                 = done_q;
    assign Error_o                = err_q;
endmodule

// File: tb/tb_share_write_master.sv
// Directed scoreboard bench for share_write_master.
// Expected bus writes are queued on line accept and popped on bus accept.
module tb_share_write_master;
    localparam logic [63:0] INIT  = 64'h0000_0000_0000_1000;
    localparam int          DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       Start_i;
    logic [8:0] Height_i;
    logic       Halt_i;
    logic       Busy_o;
    logic       Done_o;
    logic       Error_o;

    int compared   = 0;
    int mismatched = 0;

    share_write_master_if bus ();

    share_write_master #(
        .InitialOutAddr (INIT),
        .FifoDepth      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Start_i  (Start_i),
        .Height_i (Height_i),
        .Halt_i   (Halt_i),
        .bus      (bus.master),
        .Busy_o   (Busy_o),
        .Done_o   (Done_o),
        .Error_o  (Error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd_line();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle_in();
        bus.OBValid_i       = 1'b0;
        bus.OBFirst_i       = 1'b0;
        bus.OBLast_i        = 1'b0;
        bus.AvalonWaitReq_i = 1'b0;
        Halt_i              = 1'b0;
        Start_i             = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus.OBReady_o, bus.AvalonRead_o,
            bus.AvalonWrite_o, bus.AvalonLock_o,
            Busy_o, Done_o, Error_o}, '0);
        chk({tag, "_addr"}, bus.AvalonAddr_o, '0);
        chk({tag, "_be"}, bus.AvalonByteEnable_o, '0);
        chk({tag, "_data"}, bus.AvalonWriteData_o, '0);
    endtask

    // One frame: start, feed h lines, model bus and completion cycle by cycle.
    task automatic run_frame(input int h, input int bad_last,
                             input logic [63:0] wq, input logic [63:0] hm,
                             input int restart_k, input int abort_after,
                             input bit exp_full);
        logic [511:0] sbd[$];
        logic [63:0]  sba[$];
        logic [511:0] ln;
        int sent, acc, k, edge_k;
        bit pend, full_seen, fin, run;
        sent = 0; acc = 0; k = 0; edge_k = 1000;
        pend = 0; full_seen = 0; fin = 0;
        ln = rnd_line();
        Start_i  = 1'b1;
        Height_i = 9'(h);
        @(posedge clk); #1;
        Start_i = 1'b0;
        if (h == 0) edge_k = -1;
        while (k < 300 && !fin) begin
            bus.AvalonWaitReq_i = (k < 64) ? wq[k] : 1'b0;
            Halt_i    = (k < 64) ? hm[k] : 1'b0;
            Start_i   = (k == restart_k);
            Height_i  = (k == restart_k) ? 9'd1 : 9'(h);
            bus.OBValid_i = (sent < h);
            bus.OBLine_i  = ln;
            bus.OBFirst_i = (sent == 0);
            bus.OBLast_i  = (sent == h - 1) || (sent == bad_last);
            if (abort_after > 0 && acc == abort_after) begin
                rst = 1'b1;
                bus.OBValid_i = 1'b0;
                bus.AvalonWaitReq_i = 1'b1;
                Start_i = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                bus.AvalonWaitReq_i = 1'b0;
                @(negedge clk);
                chk_zero("abort");
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    bus.OBValid_i = 1'b1;
                    @(negedge clk);
                    chk("idle_ready", bus.OBReady_o, 1'b0);
                    chk("idle_write", bus.AvalonWrite_o, 1'b0);
                end
                @(posedge clk); #1;
                idle_in();
                return;
            end
            @(negedge clk);
            if (sbd.size() == DEPTH) full_seen = 1;
            run = (h != 0) && (k <= edge_k);
            chk("ready", bus.OBReady_o,
                run && sbd.size() < DEPTH && sent < h);
            chk("write", bus.AvalonWrite_o,
                run && (pend || (sbd.size() > 0 && !Halt_i)));
            chk("lock", bus.AvalonLock_o, run);
            chk("busy", Busy_o, k <= edge_k + 1);
            chk("done", Done_o, k == edge_k + 2);
            if (k == 0) chk("err_clr", Error_o, 1'b0);
            if (bus.AvalonWrite_o && sbd.size() > 0) begin
                chk("addr", bus.AvalonAddr_o, sba[0]);
                chk("data", bus.AvalonWriteData_o, sbd[0]);
                chk("be", bus.AvalonByteEnable_o, {64{1'b1}});
            end
            if (bus.AvalonWrite_o && !bus.AvalonWaitReq_i) begin
                if (sbd.size() > 0) begin
                    void'(sbd.pop_front());
                    void'(sba.pop_front());
                end
                acc++;
                pend = 0;
                if (acc == h) edge_k = k;
            end else begin
                pend = bus.AvalonWrite_o && bus.AvalonWaitReq_i;
            end
            if (bus.OBValid_i && bus.OBReady_o) begin
                sba.push_back(INIT + 64'(sent));
                sbd.push_back(ln);
                sent++;
                ln = rnd_line();
            end
            fin = (k >= edge_k + 2);
            @(posedge clk); #1;
            k++;
        end
        idle_in();
        chk("finished", fin, 1'b1);
        chk("writes", acc, h);
        chk("sb_empty", sbd.size(), 0);
        chk("error", Error_o, bad_last >= 0);
        if (exp_full) chk("full_seen", full_seen, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        Height_i = 9'd0;
        bus.OBLine_i = '0;
        bus.AvalonReadData_i = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        // back-to-back, no stalls
        run_frame(4, -1, 64'h0, 64'h0, -1, 0, 0);
        // waitreq on line 1 for 3 cycles, FIFO fills
        run_frame(8, -1, 64'h1C, 64'h0, -1, 0, 1);
        // halt while line 2 pending
        run_frame(4, -1, 64'h18, 64'h70, -1, 0, 0);
        // early Last on 2nd line
        run_frame(3, 1, 64'h0, 64'h0, -1, 0, 0);
        // zero height, error cleared by start
        run_frame(0, -1, 64'h0, 64'h0, -1, 0, 0);
        // Start during RUN ignored
        run_frame(4, -1, 64'h0, 64'h0, 2, 0, 0);
        // reset after 2 of 5 writes, then fresh frame
        run_frame(5, -1, 64'h0, 64'h0, -1, 2, 0);
        run_frame(2, -1, 64'h0, 64'h0, -1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
